// File: rtl/lifo_pop_ctrl.sv
// Drain stage for a LIFO that exports no flags: keeps a shadow occupancy count,
// issues credit-limited pops and presents the popped words on a valid/ready stream.
module lifo_pop_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lifo_wr,
  input  logic          lifo_ud,
  input  logic [DW-1:0] lifo_data,
  output logic          lifo_rd,
  input  logic          drain_en,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [CW-1:0] occ,
  output logic          err_ud
);

  localparam logic [1:0]    IDLE    = 2'd0;
  localparam logic [1:0]    ACTIVE  = 2'd1;
  localparam logic [1:0]    STOP    = 2'd2;
  localparam logic [CW-1:0] OCC_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] OCC_ONE = CW'(1);

  logic [1:0]        state_reg, state_next;
  logic [CW-1:0]     occ_reg;
  logic              err_reg;
  logic [RD_LAT-1:0] tag_v_reg, tag_v_next;
  logic [RD_LAT-1:0] tag_l_reg, tag_l_next;
  logic [2:0]        inflight;
  logic [3:0]        committed;
  logic              credit_ok;
  logic              inc;
  logic              capture;
  logic              out_pop;

  logic [DW-1:0]     buf_data [2];
  logic              buf_last [2];
  logic              buf_rd_ptr, buf_wr_ptr;
  logic [1:0]        buf_cnt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (drain_en) state_next = ACTIVE;
      ACTIVE:  if (!drain_en) state_next = STOP;
      STOP: begin
        if (drain_en)           state_next = ACTIVE;
        else if (inflight == 0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (pop issue) ----------------
  // Credit counts words that will still be outstanding after this edge, so a
  // word leaving the buffer this cycle frees its slot for a same-cycle pop.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {2'b00, tag_v_reg[i]};
    committed = {1'b0, inflight} + {2'b00, buf_cnt} - {3'b000, out_pop};
    credit_ok = (committed < 4'd2);
    lifo_rd   = (state_reg == ACTIVE) && (occ_reg != '0) && !lifo_wr && credit_ok;
  end

  // ---------------- shadow occupancy ----------------
  assign inc = lifo_wr && (occ_reg < OCC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else begin
      case ({inc, lifo_rd})
        2'b10:   occ_reg <= occ_reg + OCC_ONE;
        2'b01:   occ_reg <= occ_reg - OCC_ONE;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // ---------------- read-latency tag pipeline ----------------
  always_comb begin
    tag_v_next    = tag_v_reg << 1;
    tag_l_next    = tag_l_reg << 1;
    tag_v_next[0] = lifo_rd;
    tag_l_next[0] = lifo_rd && (occ_reg == OCC_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_reg <= '0;
      tag_l_reg <= '0;
    end else begin
      tag_v_reg <= tag_v_next;
      tag_l_reg <= tag_l_next;
    end
  end

  // ---------------- 2-entry output buffer ----------------
  assign capture = tag_v_reg[RD_LAT-1];
  assign m_valid = (buf_cnt != 2'd0);
  assign out_pop = m_valid && m_ready;
  assign m_data  = buf_data[buf_rd_ptr];
  assign m_last  = buf_last[buf_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
      buf_rd_ptr <= 1'b0;
      buf_wr_ptr <= 1'b0;
      buf_cnt    <= 2'd0;
    end else begin
      if (capture) begin
        buf_data[buf_wr_ptr] <= lifo_data;
        buf_last[buf_wr_ptr] <= tag_l_reg[RD_LAT-1];
        buf_wr_ptr           <= ~buf_wr_ptr;
      end
      if (out_pop) buf_rd_ptr <= ~buf_rd_ptr;
      case ({capture, out_pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // ---------------- sticky underflow flag ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_reg <= 1'b0;
    else if (lifo_ud) err_reg <= 1'b1;
  end

  assign occ    = occ_reg;
  assign err_ud = err_reg;

endmodule

// File: tb/tb_lifo_pop_ctrl.sv
// Directed bench for lifo_pop_ctrl: a behavioural LIFO feeds two instances
// (RD_LAT=1 and RD_LAT=3); every check is an immediate assertion.
module tb_lifo_pop_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 1: RD_LAT = 1
  logic        wr1 = 0, ud1 = 0, drain1 = 0, ready1 = 0;
  logic [31:0] wdata1 = 0, q1;
  logic        rd1, valid1, last1, err1;
  logic [31:0] mdata1;
  logic [10:0] occ1;

  // instance 2: RD_LAT = 3
  logic        wr2 = 0, ud2 = 0, drain2 = 0, ready2 = 0;
  logic [31:0] wdata2 = 0, a2, b2, c2;
  logic        rd2, valid2, last2, err2;
  logic [31:0] mdata2;
  logic [10:0] occ2;

  lifo_pop_ctrl #(.DEPTH(1024), .DW(32), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .lifo_wr(wr1), .lifo_ud(ud1), .lifo_data(q1),
    .lifo_rd(rd1), .drain_en(drain1), .m_valid(valid1), .m_ready(ready1),
    .m_data(mdata1), .m_last(last1), .occ(occ1), .err_ud(err1));

  lifo_pop_ctrl #(.DEPTH(1024), .DW(32), .RD_LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .lifo_wr(wr2), .lifo_ud(ud2), .lifo_data(c2),
    .lifo_rd(rd2), .drain_en(drain2), .m_valid(valid2), .m_ready(ready2),
    .m_data(mdata2), .m_last(last2), .occ(occ2), .err_ud(err2));

  // behavioural LIFOs, one-cycle data_out (second one extended to three cycles)
  logic [31:0] stk1 [1024];
  int          sp1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp1 <= 0; q1 <= '0;
    end else if (wr1) begin
      if (sp1 < 1024) begin stk1[sp1] <= wdata1; sp1 <= sp1 + 1; end
    end else if (rd1 && sp1 > 0) begin
      q1 <= stk1[sp1-1]; sp1 <= sp1 - 1;
    end
  end

  logic [31:0] stk2 [16];
  int          sp2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp2 <= 0; a2 <= '0; b2 <= '0; c2 <= '0;
    end else begin
      b2 <= a2; c2 <= b2;
      if (wr2) begin
        if (sp2 < 16) begin stk2[sp2] <= wdata2; sp2 <= sp2 + 1; end
      end else if (rd2 && sp2 > 0) begin
        a2 <= stk2[sp2-1]; sp2 <= sp2 - 1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  int          rdc1, viol1, ngot1, cyc1;
  logic [31:0] got1_d [16];
  logic        got1_l [16];
  int          got1_c [16];
  int          rdc2, ngot2;
  logic [31:0] got2_d [16];
  logic        got2_l [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr1();
    rdc1 = 0; viol1 = 0; ngot1 = 0;
  endtask

  task automatic sample1();
    #1;
    cyc1++;
    if (rd1) rdc1++;
    if (rd1 && wr1) viol1++;
    if (occ1 > 11'd1024) viol1++;
    if (valid1 && ready1) begin
      if (ngot1 < 16) begin
        got1_d[ngot1] = mdata1; got1_l[ngot1] = last1; got1_c[ngot1] = cyc1;
      end
      ngot1++;
    end
  endtask

  task automatic run1(input int n);
    repeat (n) begin sample1(); tick(); end
  endtask

  task automatic push1(input logic [31:0] v);
    tick(); wr1 = 1'b1; wdata1 = v; sample1();
    tick(); wr1 = 1'b0; sample1();
  endtask

  task automatic sample2();
    #1;
    if (rd2) rdc2++;
    if (valid2 && ready2) begin
      if (ngot2 < 16) begin got2_d[ngot2] = mdata2; got2_l[ngot2] = last2; end
      ngot2++;
    end
  endtask

  task automatic run2(input int n);
    repeat (n) begin sample2(); tick(); end
  endtask

  task automatic push2(input logic [31:0] v);
    tick(); wr2 = 1'b1; wdata2 = v;
    tick(); wr2 = 1'b0;
  endtask

  initial begin
    bit dropped;
    cyc1 = 0; rdc2 = 0; ngot2 = 0;
    clr1();

    // reset state
    tick(); tick(); #1;
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_occ",   32'(occ1),   32'd0);
    chk("rst_rd",    32'(rd1),    32'd0);
    chk("rst_err",   32'(err1),   32'd0);
    chk("rst_data",  mdata1,      32'd0);
    chk("rst_last",  32'(last1),  32'd0);
    rst_n = 1'b1;

    // 1: push A,B,C then drain -> C,B,A back to back, last only on A
    push1(32'hA); push1(32'hB); push1(32'hC);
    chk("t1_occ3", 32'(occ1), 32'd3);
    clr1(); drain1 = 1'b1; ready1 = 1'b1;
    run1(20);
    chk("t1_nwords", 32'(ngot1), 32'd3);
    chk("t1_d0", got1_d[0], 32'hC);
    chk("t1_d1", got1_d[1], 32'hB);
    chk("t1_d2", got1_d[2], 32'hA);
    chk("t1_l0", 32'(got1_l[0]), 32'd0);
    chk("t1_l1", 32'(got1_l[1]), 32'd0);
    chk("t1_l2", 32'(got1_l[2]), 32'd1);
    chk("t1_b2b", 32'(got1_c[2] - got1_c[0]), 32'd2);
    chk("t1_nrd", 32'(rdc1), 32'd3);
    chk("t1_occ0", 32'(occ1), 32'd0);
    chk("t1_err", 32'(err1), 32'd0);

    // 2: backpressure -> exactly two pops, head held, then the rest follows
    drain1 = 1'b0; run1(3);
    for (int i = 0; i < 5; i++) push1(32'h100 + 32'(i));
    chk("t2_occ5", 32'(occ1), 32'd5);
    clr1(); ready1 = 1'b0; drain1 = 1'b1;
    run1(5);
    chk("t2_hold_a", mdata1, 32'h104);
    run1(5);
    chk("t2_nrd", 32'(rdc1), 32'd2);
    chk("t2_occ3", 32'(occ1), 32'd3);
    chk("t2_valid", 32'(valid1), 32'd1);
    chk("t2_hold_b", mdata1, 32'h104);
    chk("t2_hold_last", 32'(last1), 32'd0);
    ready1 = 1'b1;
    run1(20);
    chk("t2_nwords", 32'(ngot1), 32'd5);
    chk("t2_first", got1_d[0], 32'h104);
    chk("t2_lastd", got1_d[4], 32'h100);
    chk("t2_lastf", 32'(got1_l[4]), 32'd1);
    chk("t2_l3", 32'(got1_l[3]), 32'd0);
    chk("t2_occ0", 32'(occ1), 32'd0);

    // 3: pushes interleaved with draining -> no same-cycle push/pop
    drain1 = 1'b0; run1(3);
    for (int i = 0; i < 4; i++) push1(32'h200 + 32'(i));
    clr1(); drain1 = 1'b1; ready1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr1 = i[0]; wdata1 = 32'h300 + 32'(i);
      sample1(); tick();
    end
    wr1 = 1'b0;
    run1(20);
    chk("t3_viol", 32'(viol1), 32'd0);
    chk("t3_nrd", 32'(rdc1), 32'd12);
    chk("t3_nwords", 32'(ngot1), 32'd12);
    chk("t3_occ0", 32'(occ1), 32'd0);

    // 4: overfill with drain off -> saturates at DEPTH, no pops
    drain1 = 1'b0; run1(3);
    clr1();
    for (int i = 0; i < 1024; i++) push1(32'(i));
    chk("t4_occ_full", 32'(occ1), 32'd1024);
    push1(32'hDEAD); push1(32'hBEEF);
    chk("t4_occ_sat", 32'(occ1), 32'd1024);
    chk("t4_nrd", 32'(rdc1), 32'd0);

    // 5: RD_LAT=3, drain_en dropped the cycle after the first pop
    push2(32'h500); push2(32'h501); push2(32'h502);
    #1;
    chk("t5_occ3", 32'(occ2), 32'd3);
    ready2 = 1'b1; drain2 = 1'b1; dropped = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sample2(); tick();
      if (rdc2 >= 1 && !dropped) begin drain2 = 1'b0; dropped = 1'b1; end
    end
    chk("t5_nrd", 32'(rdc2), 32'd2);
    chk("t5_nwords", 32'(ngot2), 32'd2);
    chk("t5_d0", got2_d[0], 32'h502);
    chk("t5_d1", got2_d[1], 32'h501);
    chk("t5_l1", 32'(got2_l[1]), 32'd0);
    chk("t5_occ1", 32'(occ2), 32'd1);
    chk("t5_idle", 32'(u2.state_reg), 32'd0);
    drain2 = 1'b1;
    run2(15);
    chk("t5_nrd_b", 32'(rdc2), 32'd3);
    chk("t5_d2", got2_d[2], 32'h500);
    chk("t5_l2", 32'(got2_l[2]), 32'd1);
    chk("t5_occ0", 32'(occ2), 32'd0);

    // 6: async reset with two buffered words, then sticky underflow flag
    clr1(); ready1 = 1'b0; drain1 = 1'b1;
    run1(8);
    chk("t6_nrd", 32'(rdc1), 32'd2);
    chk("t6_occ", 32'(occ1), 32'd1022);
    chk("t6_valid_pre", 32'(valid1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(valid1), 32'd0);
    chk("t6_occ_rst", 32'(occ1), 32'd0);
    drain1 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick(); ud1 = 1'b1;
    sample1();
    chk("t6_err_pre", 32'(err1), 32'd0);
    tick(); ud1 = 1'b0;
    #1;
    chk("t6_err_set", 32'(err1), 32'd1);
    run1(5);
    chk("t6_err_sticky", 32'(err1), 32'd1);
    chk("t6_occ_ud", 32'(occ1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
